prv32_ex_mem_stage: RTL and testbench

EX→MEM pipeline stage directly downstream of the ALU. It captures the ALU result and flags, resolves RV32I branch and jump conditions from the flags, and raises a one-cycle redirect to fetch. It holds one instruction with a valid/ready handshake and forwards it to the MEM stage.

---
 rtl/prv32_ex_mem_stage.sv | 171 +++++++++++++++++
 tb/tb_prv32_ex_mem_stage.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/prv32_ex_mem_stage.sv
// EX->MEM pipeline register: captures ALU result, resolves branch/jump, pulses redirect or misalign trap.
// Optional BRANCH_STATS_EN adds stat_branches/stat_taken counters.
module prv32_ex_mem_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic [31:0] alu_r,
    input  logic        cf,
    input  logic        zf,
    input  logic        vf,
    input  logic        sf,
    input  logic        is_branch,
    input  logic        is_jump,
    input  logic [2:0]  funct3,
    input  logic [31:0] target_pc,
    input  logic [31:0] pc_plus4,
    input  logic [31:0] rs2_data,
    input  logic [4:0]  rd,
    input  logic        reg_write,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        flush,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_result,
    output logic [31:0] mem_store_data,
    output logic [4:0]  mem_rd,
    output logic        mem_reg_write,
    output logic        mem_mem_read,
    output logic        mem_mem_write,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic        misalign_trap
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0] stat_branches,
    output logic [31:0] stat_taken
`endif
);

    localparam int unsigned XLEN = 32;
    localparam int unsigned REGW = 5;

    logic            valid_q, valid_d;
    logic [XLEN-1:0] result_q, result_d;
    logic [XLEN-1:0] sdata_q, sdata_d;
    logic [REGW-1:0] rd_q, rd_d;
    logic            rw_q, rw_d, mr_q, mr_d, mw_q, mw_d;
    logic            redirect_q, redirect_d;
    logic            trap_q, trap_d;
    logic [XLEN-1:0] rpc_q, rpc_d;

    logic accept_c, cond_c, taken_c, misaligned_c;

    assign ex_ready     = ~flush & (~valid_q | mem_ready);
    assign accept_c     = ex_valid & ex_ready;
    assign taken_c      = is_jump | (is_branch & cond_c);
    assign misaligned_c = taken_c & (target_pc[1:0] != 2'b00);

    // Branch condition from subtract-mode flags (rs1 - rs2)
    always_comb begin
        cond_c = 1'b0;
        case (funct3)
            3'b000:  cond_c = zf;
            3'b001:  cond_c = ~zf;
            3'b100:  cond_c = sf ^ vf;
            3'b101:  cond_c = ~(sf ^ vf);
            3'b110:  cond_c = ~cf;
            3'b111:  cond_c = cf;
            default: cond_c = 1'b0;
        endcase
    end

    always_comb begin
        valid_d    = valid_q;
        result_d   = result_q;
        sdata_d    = sdata_q;
        rd_d       = rd_q;
        rw_d       = rw_q;
        mr_d       = mr_q;
        mw_d       = mw_q;
        rpc_d      = rpc_q;
        redirect_d = 1'b0;
        trap_d     = 1'b0;
        if (flush) begin
            valid_d = 1'b0;
        end else if (accept_c) begin
            valid_d    = 1'b1;
            result_d   = is_jump ? pc_plus4 : alu_r;
            sdata_d    = rs2_data;
            rd_d       = rd;
            // A trapped entry still advances but must not commit side effects
            rw_d       = reg_write & ~misaligned_c;
            mr_d       = mem_read  & ~misaligned_c;
            mw_d       = mem_write & ~misaligned_c;
            redirect_d = taken_c & ~misaligned_c;
            trap_d     = misaligned_c;
            if (taken_c && !misaligned_c) begin
                rpc_d = target_pc;
            end
        end else if (mem_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= 1'b0;
            result_q   <= '0;
            sdata_q    <= '0;
            rd_q       <= '0;
            rw_q       <= 1'b0;
            mr_q       <= 1'b0;
            mw_q       <= 1'b0;
            redirect_q <= 1'b0;
            trap_q     <= 1'b0;
            rpc_q      <= RESET_PC;
        end else begin
            valid_q    <= valid_d;
            result_q   <= result_d;
            sdata_q    <= sdata_d;
            rd_q       <= rd_d;
            rw_q       <= rw_d;
            mr_q       <= mr_d;
            mw_q       <= mw_d;
            redirect_q <= redirect_d;
            trap_q     <= trap_d;
            rpc_q      <= rpc_d;
        end
    end

    assign mem_valid      = valid_q;
    assign mem_result     = result_q;
    assign mem_store_data = sdata_q;
    assign mem_rd         = rd_q;
    assign mem_reg_write  = rw_q;
    assign mem_mem_read   = mr_q;
    assign mem_mem_write  = mw_q;
    assign redirect       = redirect_q;
    assign redirect_pc    = rpc_q;
    assign misalign_trap  = trap_q;

`ifdef BRANCH_STATS_EN
    logic [XLEN-1:0] br_cnt_q, br_cnt_d, tk_cnt_q, tk_cnt_d;

    // Counters wrap naturally at 2^32
    always_comb begin
        br_cnt_d = br_cnt_q;
        tk_cnt_d = tk_cnt_q;
        if (accept_c && is_branch) br_cnt_d = br_cnt_q + XLEN'(1);
        if (accept_c && taken_c)   tk_cnt_d = tk_cnt_q + XLEN'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_cnt_q <= '0;
            tk_cnt_q <= '0;
        end else begin
            br_cnt_q <= br_cnt_d;
            tk_cnt_q <= tk_cnt_d;
        end
    end

    assign stat_branches = br_cnt_q;
    assign stat_taken    = tk_cnt_q;
`endif

endmodule

// File: tb/tb_prv32_ex_mem_stage.sv
// Bench for prv32_ex_mem_stage: directed plan steps then random traffic against an operand-level model.
module tb_prv32_ex_mem_stage;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid, ex_ready;
    logic [31:0] alu_r;
    logic        cf, zf, vf, sf;
    logic        is_branch, is_jump;
    logic [2:0]  funct3;
    logic [31:0] target_pc, pc_plus4, rs2_data;
    logic [4:0]  rd;
    logic        reg_write, mem_read, mem_write, flush;
    logic        mem_valid, mem_ready;
    logic [31:0] mem_result, mem_store_data;
    logic [4:0]  mem_rd;
    logic        mem_reg_write, mem_mem_read, mem_mem_write;
    logic        redirect, misalign_trap;
    logic [31:0] redirect_pc;
`ifdef BRANCH_STATS_EN
    logic [31:0] stat_branches, stat_taken;
`endif

    always #5 clk = ~clk;

    prv32_ex_mem_stage #(.RESET_PC(RST_PC)) dut (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_ready(ex_ready),
        .alu_r(alu_r), .cf(cf), .zf(zf), .vf(vf), .sf(sf),
        .is_branch(is_branch), .is_jump(is_jump), .funct3(funct3),
        .target_pc(target_pc), .pc_plus4(pc_plus4), .rs2_data(rs2_data), .rd(rd),
        .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write), .flush(flush),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_result(mem_result),
        .mem_store_data(mem_store_data), .mem_rd(mem_rd),
        .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
        .redirect(redirect), .redirect_pc(redirect_pc), .misalign_trap(misalign_trap)
`ifdef BRANCH_STATS_EN
        , .stat_branches(stat_branches), .stat_taken(stat_taken)
`endif
    );

    int checks = 0;
    int passes = 0;

    // Reference state, described as "what MEM currently holds"
    logic [31:0] op_a, op_b;
    logic        m_valid, m_rw, m_mr, m_mw, m_redirect, m_trap;
    logic [31:0] m_result, m_sdata, m_rpc;
    logic [4:0]  m_rd;
    logic [31:0] m_nbr, m_ntk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // RV32I branch semantics stated on the source operands
    function automatic logic ref_cond(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        case (f3)
            3'b000:  return a == b;
            3'b001:  return a != b;
            3'b100:  return $signed(a) <  $signed(b);
            3'b101:  return $signed(a) >= $signed(b);
            3'b110:  return a <  b;
            3'b111:  return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        m_valid = 0; m_rw = 0; m_mr = 0; m_mw = 0; m_redirect = 0; m_trap = 0;
        m_result = 0; m_sdata = 0; m_rd = 0; m_rpc = RST_PC; m_nbr = 0; m_ntk = 0;
    endtask

    // Drive one cycle of inputs; flags come from an emulated ALU subtract a-b
    task automatic drive(input logic v, input logic br, input logic jp, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] tgt,
                         input logic [31:0] alu, input logic [31:0] pc4, input logic [31:0] sd,
                         input logic [4:0] r, input logic rw, input logic mr, input logic mw,
                         input logic fl, input logic mrdy);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, ~b} + 33'd1;
        op_a = a; op_b = b;
        cf = sum[32]; zf = (sum[31:0] == 32'd0); sf = sum[31];
        vf = (a[31] != b[31]) && (sum[31] != a[31]);
        ex_valid = v; is_branch = br; is_jump = jp; funct3 = f3; target_pc = tgt;
        alu_r = alu; pc_plus4 = pc4; rs2_data = sd; rd = r;
        reg_write = rw; mem_read = mr; mem_write = mw; flush = fl; mem_ready = mrdy;
    endtask

    task automatic idle(input logic mrdy);
        drive(0, 0, 0, 3'b010, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, mrdy);
    endtask

    task automatic check_outputs();
        chk("mem_valid", mem_valid, m_valid);
        chk("mem_result", mem_result, m_result);
        chk("mem_store_data", mem_store_data, m_sdata);
        chk("mem_rd", mem_rd, m_rd);
        chk("mem_reg_write", mem_reg_write, m_rw);
        chk("mem_mem_read", mem_mem_read, m_mr);
        chk("mem_mem_write", mem_mem_write, m_mw);
        chk("redirect", redirect, m_redirect);
        chk("misalign_trap", misalign_trap, m_trap);
        chk("redirect_pc", redirect_pc, m_rpc);
`ifdef BRANCH_STATS_EN
        chk("stat_branches", stat_branches, m_nbr);
        chk("stat_taken", stat_taken, m_ntk);
`endif
    endtask

    // Check ready, clock once, advance the model, check registered outputs
    task automatic step();
        logic rdy, acc, tk, mis;
        #1;
        rdy = !flush && (!m_valid || mem_ready);
        chk("ex_ready", ex_ready, rdy);
        acc = ex_valid && rdy;
        tk  = is_jump || (is_branch && ref_cond(funct3, op_a, op_b));
        mis = tk && (target_pc[1:0] != 2'b00);
        @(posedge clk); #1;
        m_redirect = 0; m_trap = 0;
        if (acc) begin
            m_valid  = 1;
            m_result = is_jump ? pc_plus4 : alu_r;
            m_sdata  = rs2_data;
            m_rd     = rd;
            m_rw     = reg_write && !mis;
            m_mr     = mem_read && !mis;
            m_mw     = mem_write && !mis;
            m_redirect = tk && !mis;
            m_trap   = mis;
            if (tk && !mis) m_rpc = target_pc;
            if (is_branch) m_nbr = m_nbr + 1;
            if (tk) m_ntk = m_ntk + 1;
        end else if (flush || mem_ready) begin
            m_valid = 0;
        end
        check_outputs();
    endtask

    initial begin
        rst_n = 0;
        model_reset();
        idle(1);
        #12;
        check_outputs();
        @(negedge clk); rst_n = 1;
        @(posedge clk); #1;

        // Plain ALU op then drain
        drive(1, 0, 0, 3'b000, 1, 2, 0, 32'h15, 32'h4, 32'h0, 5'd5, 1, 0, 0, 0, 1); step();
        idle(1); step();

        // BEQ taken / not taken
        drive(1, 1, 0, 3'b000, 7, 7, 32'h100, 32'h0, 32'h8, 0, 0, 0, 0, 0, 0, 1); step();
        idle(1); step();
        drive(1, 1, 0, 3'b000, 7, 8, 32'h200, 32'h0, 32'h8, 0, 0, 0, 0, 0, 0, 1); step();

        // BLT with sf=vf=1, BGEU cf=1, BLTU cf=1, funct3=010
        drive(1, 1, 0, 3'b100, 32'h7fff_ffff, 32'hffff_ffff, 32'h300, 0, 0, 0, 0, 0, 0, 0, 0, 1); step();
        drive(1, 1, 0, 3'b111, 5, 3, 32'h140, 0, 0, 0, 0, 0, 0, 0, 0, 1); step();
        drive(1, 1, 0, 3'b110, 5, 3, 32'h180, 0, 0, 0, 0, 0, 0, 0, 0, 1); step();
        drive(1, 1, 0, 3'b010, 9, 9, 32'h1c0, 0, 0, 0, 0, 0, 0, 0, 0, 1); step();

        // JAL held for 3 cycles while EX keeps offering another op
        drive(1, 0, 1, 3'b000, 0, 1, 32'h80, 32'h999, 32'h24, 0, 5'd1, 1, 0, 0, 0, 0); step();
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 0, 3'b000, 0, 0, 0, 32'h77, 0, 0, 5'd2, 1, 0, 0, 0, 0); step();
        end
        idle(1); step();

        // Misaligned taken branch
        drive(1, 1, 0, 3'b000, 4, 4, 32'h102, 32'h5, 0, 32'hdead, 5'd3, 1, 1, 1, 0, 1); step();
        idle(1); step();

        // Four back-to-back ops, flush on the third (a taken jump that must not redirect)
        drive(1, 0, 0, 3'b000, 0, 0, 0, 32'ha1, 0, 0, 5'd1, 1, 0, 0, 0, 1); step();
        drive(1, 0, 0, 3'b000, 0, 0, 0, 32'ha2, 0, 0, 5'd2, 1, 0, 0, 0, 1); step();
        drive(1, 0, 1, 3'b000, 0, 0, 32'h400, 32'ha3, 0, 0, 5'd3, 1, 0, 0, 1, 1); step();
        drive(1, 0, 0, 3'b000, 0, 0, 0, 32'ha4, 0, 0, 5'd4, 1, 0, 0, 0, 1); step();

        // Async reset while an entry is held
        drive(1, 0, 0, 3'b000, 0, 0, 0, 32'hb1, 0, 32'h55, 5'd9, 1, 1, 0, 0, 0); step();
        idle(0); step();
        #2; rst_n = 0; #1;
        model_reset();
        check_outputs();
        @(negedge clk); rst_n = 1;
        @(posedge clk); #1;

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            logic [31:0] a, b, tgt;
            a = $urandom; b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            tgt = {$urandom_range(0, 32'h0fff_ffff), 4'b0};
            if ($urandom_range(0, 3) == 0) tgt[1:0] = 2'($urandom_range(1, 3));
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 5) == 0),
                  3'($urandom), a, b, tgt, $urandom, $urandom, $urandom, 5'($urandom),
                  1'($urandom), 1'($urandom), 1'($urandom),
                  1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 9) < 7));
            step();
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
